// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a DATA_WIDTH-cycle shift-add multiply.
// Latency: 1 cycle, or DATA_WIDTH+1 cycles for MUL. The result is held in DONE until out_ready.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALU_Op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  N,
  output logic                  Z,
  output logic                  C,
  output logic                  V,
  output logic                  op_err
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LSL = 4'b0100;
  localparam logic [3:0] OP_LSR = 4'b0101;
  localparam logic [3:0] OP_ASR = 4'b0110;
  localparam logic [3:0] OP_ROR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [SHAMT_W-1:0]      cnt;

  logic [SHAMT_W-1:0]      sh;
  logic [SHAMT_W-1:0]      lsl_idx;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH-1:0]   res;
  logic                    res_c;
  logic                    res_v;
  logic                    res_err;

  assign sh       = B[SHAMT_W-1:0];
  // DATA_WIDTH - sh modulo DATA_WIDTH: last bit out of LSL, and the left part of ROR.
  assign lsl_idx  = SHAMT_W'(0) - sh;
  assign sum      = {1'b0, A} + {1'b0, B};
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (ALU_Op)
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_ADD: begin
        res   = sum[MSB:0];
        res_c = sum[DATA_WIDTH];
        res_v = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
      end
      OP_SUB: begin
        res   = A - B;
        res_c = (A >= B);
        res_v = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
      end
      OP_LSL: begin
        res   = A << sh;
        res_c = (sh != '0) ? A[lsl_idx] : 1'b0;
      end
      OP_LSR: begin
        res   = A >> sh;
        res_c = (sh != '0) ? A[sh - SHAMT_W'(1)] : 1'b0;
      end
      OP_ASR: begin
        res   = $signed(A) >>> sh;
        res_c = (sh != '0) ? A[sh - SHAMT_W'(1)] : 1'b0;
      end
      OP_ROR: begin
        // With sh=0 both halves equal A, so the OR returns A unchanged.
        res   = (A >> sh) | (A << lsl_idx);
        res_c = (sh != '0) ? res[MSB] : 1'b0;
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      op_err    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (ALU_Op == OP_MUL) begin
              state  <= BUSY;
              mcand  <= {{DATA_WIDTH{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              Result    <= res;
              N         <= res[MSB];
              Z         <= (res == '0);
              C         <= res_c;
              V         <= res_v;
              op_err    <= res_err;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == SHAMT_W'(DATA_WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Result    <= acc_next[MSB:0];
            N         <= acc_next[MSB];
            Z         <= (acc_next[MSB:0] == '0);
            C         <= |acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
            V         <= 1'b0;
            op_err    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at DATA_WIDTH=32.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALU_Op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;
  logic        N, Z, C, V, op_err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Op(ALU_Op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .N(N), .Z(Z), .C(C), .V(V), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic n, input logic z,
                         input logic c, input logic v, input logic e);
    chk({tag, ".result"}, Result, r);
    chk({tag, ".N"}, N, n);
    chk({tag, ".Z"}, Z, z);
    chk({tag, ".C"}, C, c);
    chk({tag, ".V"}, V, v);
    chk({tag, ".op_err"}, op_err, e);
  endtask

  // Issue one op, then count cycles until out_valid; noise pulses in_valid while waiting.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input int exp_lat, input bit noise);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    A = a; B = b; ALU_Op = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise && !out_valid) begin
        chk({tag, ".busy_in_ready"}, in_ready, 1'b0);
        in_valid = (lat % 3 == 0);
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALU_Op = 4'b0011;
      end
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".pop_out_valid"}, out_valid, 1'b0);
    chk({tag, ".pop_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk_out("rst", 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Signed overflow on ADD, latency 1
    issue("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0011, 1, 0);
    chk_out("add_ovf", 32'h8000_0000, 1, 0, 0, 1, 0);
    pop("add_ovf");

    // Reset 5 cycles into a MUL
    @(negedge clk);
    A = 32'd9; B = 32'd9; ALU_Op = 4'b1000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.in_ready", in_ready, 1'b1);
    chk_out("midrst", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    issue("post_rst_add", 32'd2, 32'd3, 4'b0011, 1, 0);
    chk_out("post_rst_add", 32'd5, 0, 0, 0, 0, 0);
    pop("post_rst_add");

    // SUB
    issue("sub_eq", 32'h5, 32'h5, 4'b1011, 1, 0);
    chk_out("sub_eq", 32'h0, 0, 1, 1, 0, 0);
    pop("sub_eq");
    issue("sub_borrow", 32'h0, 32'h1, 4'b1011, 1, 0);
    chk_out("sub_borrow", 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    pop("sub_borrow");

    // Logic ops
    issue("or", 32'hF0F0_0000, 32'h0000_0F0F, 4'b0001, 1, 0);
    chk_out("or", 32'hF0F0_0F0F, 1, 0, 0, 0, 0);
    pop("or");
    issue("xor", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0010, 1, 0);
    chk_out("xor", 32'h0, 0, 1, 0, 0, 0);
    pop("xor");

    // Shifts and rotates; upper bits of B must be ignored
    issue("asr", 32'h8000_0010, 32'h0000_0024, 4'b0110, 1, 0);
    chk_out("asr", 32'hF800_0001, 1, 0, 0, 0, 0);
    pop("asr");
    issue("lsl", 32'h8000_0001, 32'hFFFF_FFE1, 4'b0100, 1, 0);
    chk_out("lsl", 32'h0000_0002, 0, 0, 1, 0, 0);
    pop("lsl");
    issue("lsr", 32'h0000_0003, 32'h0000_0001, 4'b0101, 1, 0);
    chk_out("lsr", 32'h0000_0001, 0, 0, 1, 0, 0);
    pop("lsr");
    issue("ror1", 32'h0000_0001, 32'h0000_0001, 4'b0111, 1, 0);
    chk_out("ror1", 32'h8000_0000, 1, 0, 1, 0, 0);
    pop("ror1");
    issue("ror0", 32'h1234_5678, 32'h0000_0020, 4'b0111, 1, 0);
    chk_out("ror0", 32'h1234_5678, 0, 0, 0, 0, 0);
    pop("ror0");

    // MUL with in_valid noise during BUSY
    issue("mul_hi", 32'h0001_0000, 32'h0001_0000, 4'b1000, 33, 1);
    chk_out("mul_hi", 32'h0, 0, 1, 1, 0, 0);
    pop("mul_hi");
    issue("mul_7x6", 32'd7, 32'd6, 4'b1000, 33, 1);
    chk_out("mul_7x6", 32'd42, 0, 0, 0, 0, 0);
    pop("mul_7x6");

    // Backpressure: AND result held for 10 cycles while in_valid is offered
    issue("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 1, 0);
    chk_out("and", 32'h0F00_0F00, 0, 0, 0, 0, 0);
    held = Result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 32'h1; B = 32'h1; ALU_Op = 4'b0011;
      chk("bp.out_valid", out_valid, 1'b1);
      chk("bp.in_ready", in_ready, 1'b0);
      chk_out("bp", 32'h0F00_0F00, 0, 0, 0, 0, 0);
    end
    in_valid = 1'b0;
    pop("and");

    // Undefined opcode, then cleared by a legal op
    issue("undef", 32'h5, 32'h5, 4'b1111, 1, 0);
    chk_out("undef", 32'h0, 0, 1, 0, 0, 1);
    pop("undef");
    issue("clr_err", 32'd2, 32'd3, 4'b0011, 1, 0);
    chk_out("clr_err", 32'd5, 0, 0, 0, 0, 0);
    pop("clr_err");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
